// File: rtl/branch_pkg.sv
// Shared types for the branch predictor / resolver pair: predictor
// counter states, resolver FSM encoding and the tracked-branch entry.
package branch_pkg;

  // 2-bit predictor: strong/weak not-taken, weak/strong taken
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } pred_state_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } res_state_t;

  localparam int BR_PC_W = 8;

  typedef struct packed {
    logic [BR_PC_W-1:0] pc;
    logic               taken;
  } entry_t;

endpackage

// File: rtl/branch_queue.sv
// In-order tracking FIFO for in-flight branches; clear wins over push.
module branch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign count   = count_reg;
  // Head is read asynchronously so a branch can resolve the cycle after its push
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Compares execute outcomes against queued predictions, emits training
// pulses, flushes wrong-path branches and keeps saturating statistics.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             train_valid,
  output logic             train_taken,
  output logic [PC_W-1:0]  train_pc,
  output logic             mispredict,
  output logic             flush,
  output logic             err_underflow,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  res_state_t state_reg, state_next;

  logic [PC_W:0]            q_head;
  logic [$clog2(DEPTH):0]   q_count;
  logic                     q_full;
  logic                     q_empty;
  logic                     res_fire;
  logic                     mis;
  logic                     push;

  logic             train_valid_reg;
  logic             train_taken_reg;
  logic [PC_W-1:0]  train_pc_reg;
  logic             mispredict_reg;
  logic             err_underflow_reg;
  logic [CNT_W-1:0] br_count_reg;
  logic [CNT_W-1:0] mp_count_reg;

  assign pred_ready = (state_reg == ST_RUN) && !q_full && !rst;
  assign push       = pred_valid && pred_ready;
  assign res_fire   = res_valid && (q_count != '0);
  assign mis        = res_fire && (res_taken != q_head[0]);

  // A mispredict clears the whole queue, which also drops a same-cycle push
  branch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + 1)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({pred_pc, pred_taken}),
    .pop   (res_fire),
    .clear (mis),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (mis) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      train_valid_reg   <= 1'b0;
      train_taken_reg   <= 1'b0;
      train_pc_reg      <= '0;
      mispredict_reg    <= 1'b0;
      err_underflow_reg <= 1'b0;
      br_count_reg      <= '0;
      mp_count_reg      <= '0;
    end else begin
      train_valid_reg <= res_fire;
      mispredict_reg  <= mis;
      if (res_fire) begin
        train_taken_reg <= res_taken;
        train_pc_reg    <= q_head[PC_W:1];
        if (br_count_reg != '1) br_count_reg <= br_count_reg + CNT_W'(1);
      end
      if (mis && mp_count_reg != '1) mp_count_reg <= mp_count_reg + CNT_W'(1);
      if (res_valid && q_empty) err_underflow_reg <= 1'b1;
    end
  end

  assign train_valid   = train_valid_reg;
  assign train_taken   = train_taken_reg;
  assign train_pc      = train_pc_reg;
  assign mispredict    = mispredict_reg;
  assign flush         = mispredict_reg;
  assign err_underflow = err_underflow_reg;
  assign br_count      = br_count_reg;
  assign mp_count      = mp_count_reg;

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolution-side companion to the 2-bit branch predictor. Fetch pushes each predicted branch (PC, predicted direction) into an in-order tracking queue. Execute reports the actual outcome for the oldest branch; the block compares it with the stored prediction and emits a one-cycle training pulse that feeds the predictor's outcome input. On a misprediction it also flushes all younger in-flight branches and keeps saturating statistics counters.

## Interface
- DEPTH, 4: maximum in-flight branches; power of two, at least 2.
- PC_W, 8: branch PC width.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_valid  in  1  fetch issues a predicted branch this cycle.
- pred_taken  in  1  predicted direction (predictor output y).
- pred_pc  in  PC_W  PC of the predicted branch.
- pred_ready  out  1  push accepted; combinational: state==RUN && count<DEPTH && !rst.
- res_valid  in  1  execute resolves the oldest in-flight branch.
- res_taken  in  1  actual direction.
- train_valid  out  1  registered one-cycle pulse; the predictor updates on it.
- train_taken  out  1  registered actual direction; drives the predictor's `in`.
- train_pc  out  PC_W  registered PC of the resolved branch.
- mispredict  out  1  registered one-cycle pulse when res_taken differs from the stored prediction.
- flush  out  1  registered; equals mispredict; fetch discards wrong-path work.
- err_underflow  out  1  sticky; set by res_valid while the queue is empty.
- br_count  out  CNT_W  number of resolved branches; saturates at all-ones.
- mp_count  out  CNT_W  number of mispredicts; saturates at all-ones.

## Operation
- States: RUN and FLUSH. Reset enters RUN. RUN goes to FLUSH on a mispredict. FLUSH returns to RUN after exactly one cycle.
- Push: on pred_valid && pred_ready, write {pred_pc, pred_taken} at the tail. When pred_ready=0, the push is dropped silently.
- Resolve: on res_valid && count>0, pop the head.
  - Next cycle: train_valid=1, train_taken=res_taken, train_pc=head pc.
  - br_count increments.
- Mispredict: resolve with res_taken != head.taken.
  - Next cycle: mispredict=1, flush=1, mp_count increments.
  - The entire queue empties, including entries younger than the head.
  - State goes to FLUSH.
- Push and correct resolve in the same cycle: both happen; count is unchanged.
- Push and mispredict in the same cycle: the push is discarded as wrong-path; the queue ends empty.
- res_valid with an empty queue: ignored (no train pulse, no counter change); err_underflow set to 1.
- Both counters saturate at 2^CNT_W-1 and do not wrap.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- During FLUSH: pred_ready=0. res_valid is treated as underflow because the queue is empty.

## Timing
- Resolve-to-train latency: 1 cycle. Push-to-resolvable: the entry can be resolved in the cycle after the push.
- train_valid, mispredict and flush are high for exactly one cycle per event.
- Reset (rst high at an edge), including mid-operation:
  - queue emptied, state=RUN;
  - all registered outputs 0: train_*, mispredict, flush, err_underflow, br_count, mp_count;
  - pred_ready=0 while rst is high, 1 in the first cycle after rst deasserts.
- Throughput: one push and one resolve per cycle. A mispredict costs one cycle with pred_ready=0.

## Structure
- Shared package branch_pkg holds:
  - predictor state constants (S0..S3: strong/weak false, weak/strong true);
  - resolver state encoding RUN/FLUSH;
  - entry struct {pc, taken}.
- Sub-module branch_queue: synchronous FIFO of DEPTH entries with push, pop, clear, count and full/empty. Clear has priority over push.

## Test plan
- Reset, then push pc=0x10 taken=1, resolve taken=1 -> next cycle train_valid=1, train_pc=0x10, train_taken=1, mispredict=0, br_count=1.
- Push 4 branches (0x20..0x23, all predicted 0); a fifth push is dropped (pred_ready=0); resolve 0x20 taken=1 -> mispredict=flush=1, mp_count=1, queue empty; pred_ready=0 for one cycle, then 1.
- Push and mispredict-resolve in the same cycle -> queue ends empty; the pushed entry never produces train_valid.
- res_valid on an empty queue -> no train pulse, counters unchanged, err_underflow=1 until rst.
- Preload br_count to all-ones (or run 2^CNT_W resolves with CNT_W reduced to 4) -> it stays at 15.
- Assert rst with 3 entries queued -> all outputs 0; a next resolve flags underflow.
